data_stack: RTL



---
 rtl/data_stack_pkg.sv | 43 ++++
 rtl/data_stack.sv | 89 ++++++++
 2 files changed

// File: rtl/data_stack_pkg.sv
// rtl/data_stack_pkg.sv - opcode type and operand/occupancy rules for data_stack
package data_stack_pkg;

   typedef enum logic [2:0] {
      DS_NOP     = 3'd0,
      DS_PUSH    = 3'd1,
      DS_POP     = 3'd2,
      DS_REPLACE = 3'd3,
      DS_SWAP    = 3'd4,
      DS_DUP     = 3'd5,
      DS_OVER    = 3'd6,
      DS_BINOP   = 3'd7
   } ds_op_t;

   localparam logic signed [1:0] DS_DELTA_UP   = 2'sd1;
   localparam logic signed [1:0] DS_DELTA_NONE = 2'sd0;
   localparam logic signed [1:0] DS_DELTA_DOWN = -2'sd1;

   // Entries that must already be on the stack for the op to be accepted.
   function automatic logic [1:0] ds_op_min_count(input ds_op_t op);
      logic [1:0] need;
      need = 2'd0;
      case (op)
         DS_POP, DS_REPLACE, DS_DUP:      need = 2'd1;
         DS_SWAP, DS_OVER, DS_BINOP:      need = 2'd2;
         default:                         need = 2'd0;
      endcase
      return need;
   endfunction

   // Net occupancy change of an accepted op.
   function automatic logic signed [1:0] ds_op_delta(input ds_op_t op);
      logic signed [1:0] d;
      d = DS_DELTA_NONE;
      case (op)
         DS_PUSH, DS_DUP, DS_OVER: d = DS_DELTA_UP;
         DS_POP, DS_BINOP:         d = DS_DELTA_DOWN;
         default:                  d = DS_DELTA_NONE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/data_stack.sv
// rtl/data_stack.sv - shift-register operand stack with stack-machine ops and sticky error flags
module data_stack
   import data_stack_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  ds_op_t           op,
   input  logic [WIDTH-1:0] insert,
   input  logic             clear_err,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] second,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   // mem[0] is always the newest entry; pushes shift toward DEPTH-1.
   logic [WIDTH-1:0] mem [DEPTH];

   logic             lack_ops;
   logic             lack_space;
   logic             accept;
   logic signed [1:0] delta;

   always_comb begin
      delta      = ds_op_delta(op);
      lack_ops   = count < CW'(ds_op_min_count(op));
      lack_space = (delta == DS_DELTA_UP) && (count == CW'(DEPTH));
      accept     = !lack_ops && !lack_space;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // A rejection in the same cycle as clear_err still leaves its flag set.
         overflow  <= (overflow  && !clear_err) || (!accept && !lack_ops);
         underflow <= (underflow && !clear_err) || (!accept && lack_ops);

         if (accept) begin
            if (delta == DS_DELTA_UP)
               count <= count + CW'(1);
            else if (delta == DS_DELTA_DOWN)
               count <= count - CW'(1);

            case (op)
               DS_PUSH, DS_DUP, DS_OVER: begin
                  for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
                  if (op == DS_PUSH)
                     mem[0] <= insert;
                  else if (op == DS_OVER)
                     mem[0] <= mem[1];
               end
               DS_POP: begin
                  for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
                  mem[DEPTH-1] <= '0;
               end
               DS_BINOP: begin
                  mem[0] <= insert;
                  for (int i = 1; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
                  mem[DEPTH-1] <= '0;
               end
               DS_REPLACE: mem[0] <= insert;
               DS_SWAP: begin
                  mem[0] <= mem[1];
                  mem[1] <= mem[0];
               end
               default: ;
            endcase
         end
      end
   end

   // Gate by occupancy so stale words below the live region never appear.
   assign top    = (count != '0)       ? mem[0] : '0;
   assign second = (count >= CW'(2))   ? mem[1] : '0;
   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));

endmodule
